// File: rtl/stage_if_pkg.sv
// Shared types and widths for the RV32I instruction-fetch stage.
package stage_if_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned INST_W     = 32;
    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned INST_BYTES = 4;
    localparam int unsigned CNT_W      = 3;
    localparam int unsigned IDX_W      = 2;

    typedef enum logic {
        IF_FETCH = 1'b0,
        IF_HOLD  = 1'b1
    } if_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } if_id_t;

    // Replace one little-endian byte lane of an instruction word.
    function automatic logic [INST_W-1:0] put_byte(input logic [INST_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx,
                                                   input logic [BYTE_W-1:0] b);
        logic [INST_W-1:0] w;
        w = word;
        w[{idx, 3'b000} +: BYTE_W] = b;
        return w;
    endfunction

endpackage

// File: rtl/stage_if_icache.sv
// Direct-mapped one-word-per-line instruction cache; only built when ICACHE_EN is defined.
// Lookup is combinational on the word address; fills are written on the rising edge.
`ifdef ICACHE_EN
module if_icache
    import stage_if_pkg::*;
#(
    parameter int unsigned LINES = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-3:0]   lookup_word,
    output logic                hit,
    output logic [INST_W-1:0]   lookup_data,
    input  logic                we,
    input  logic [ADDR_W-3:0]   wr_word,
    input  logic [INST_W-1:0]   wr_data
);

    localparam int unsigned IX_W  = $clog2(LINES);
    localparam int unsigned TAG_W = ADDR_W - 2 - IX_W;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [INST_W-1:0] data_q [LINES];
    logic [IX_W-1:0]   rd_idx;
    logic [IX_W-1:0]   wr_idx;

    assign rd_idx      = lookup_word[IX_W-1:0];
    assign wr_idx      = wr_word[IX_W-1:0];
    assign hit         = valid_q[rd_idx] && (tag_q[rd_idx] == lookup_word[ADDR_W-3:IX_W]);
    assign lookup_data = data_q[rd_idx];

    // Valid bits are the only state that needs clearing on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_word[ADDR_W-3:IX_W];
            data_q[wr_idx] <= wr_data;
        end
    end

endmodule
`endif

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: assembles each instruction from four byte reads on the shared RAM port.
// Optional I-cache enabled by defining ICACHE_EN.
module stage_if
    import stage_if_pkg::*;
`ifdef ICACHE_EN
#(
    parameter int unsigned ICACHE_LINES = 64
)
`endif
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              br,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              mem_busy,
    output logic              ram_rd,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [BYTE_W-1:0] ram_data,
    output logic [ADDR_W-1:0] pc,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
    logic              pending_q, pending_d;
    logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
    if_id_t            out_q, out_d;
    logic              valid_q, valid_d;
    logic              cache_hit;
    logic [INST_W-1:0] cache_data;
    logic              lookup_hit;
    logic              last_byte;

    // Only a fresh fetch with nothing in flight may be served from the cache.
    assign lookup_hit = cache_hit && (issue_cnt_q == '0) && !pending_q;
    assign last_byte  = pending_q && (pend_idx_q == IDX_W'(INST_BYTES - 1));

`ifdef ICACHE_EN
    logic fill_we;

    assign fill_we = !reset && !br && (state_q == IF_FETCH) && last_byte;

    if_icache #(
        .LINES(ICACHE_LINES)
    ) u_icache (
        .clk         (clk),
        .reset       (reset),
        .lookup_word (fetch_pc_q[ADDR_W-1:2]),
        .hit         (cache_hit),
        .lookup_data (cache_data),
        .we          (fill_we),
        .wr_word     (fetch_pc_q[ADDR_W-1:2]),
        .wr_data     (put_byte(out_q.inst, pend_idx_q, ram_data))
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IF_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, byte issue/capture and RAM request decode.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issue_cnt_d = issue_cnt_q;
        pending_d   = 1'b0;
        pend_idx_d  = issue_cnt_q[IDX_W-1:0];
        out_d       = out_q;
        valid_d     = valid_q;
        ram_rd      = 1'b0;
        ram_addr    = reset ? '0 : fetch_pc_q + ADDR_W'(issue_cnt_q);

        if (!reset) begin
            if (br) begin
                fetch_pc_d  = br_addr;
                issue_cnt_d = '0;
                valid_d     = 1'b0;
                state_d     = IF_FETCH;
            end else begin
                case (state_q)
                    IF_FETCH: begin
                        if (lookup_hit) begin
                            out_d.inst  = cache_data;
                            out_d.pc    = fetch_pc_q;
                            valid_d     = 1'b1;
                            issue_cnt_d = CNT_W'(INST_BYTES);
                            state_d     = IF_HOLD;
                        end else begin
                            if ((issue_cnt_q < CNT_W'(INST_BYTES)) && !mem_busy) begin
                                ram_rd      = 1'b1;
                                issue_cnt_d = issue_cnt_q + CNT_W'(1);
                                pending_d   = 1'b1;
                            end
                            if (pending_q) begin
                                out_d.inst = put_byte(out_q.inst, pend_idx_q, ram_data);
                            end
                            if (last_byte) begin
                                out_d.pc = fetch_pc_q;
                                valid_d  = 1'b1;
                                state_d  = IF_HOLD;
                            end
                        end
                    end
                    IF_HOLD: begin
                        if (!stall) begin
                            fetch_pc_d  = fetch_pc_q + ADDR_W'(INST_BYTES);
                            issue_cnt_d = '0;
                            valid_d     = 1'b0;
                            state_d     = IF_FETCH;
                        end
                    end
                    default: state_d = IF_FETCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q  <= '0;
            issue_cnt_q <= '0;
            pending_q   <= 1'b0;
            pend_idx_q  <= '0;
            out_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            issue_cnt_q <= issue_cnt_d;
            pending_q   <= pending_d;
            pend_idx_q  <= pend_idx_d;
            out_q       <= out_d;
            valid_q     <= valid_d;
        end
    end

    assign pc         = out_q.pc;
    assign inst       = out_q.inst;
    assign inst_valid = valid_q;

endmodule

// File: tb/tb_stage_if.sv
// Directed bench for stage_if with a 1-cycle-latency byte RAM model.
// Cache-specific steps are compiled in only when ICACHE_EN is defined.
module tb_stage_if;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] br_addr = '0;
    logic        mem_busy = 1'b0;
    logic        ram_rd;
    logic [31:0] ram_addr;
    logic [7:0]  ram_data = '0;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        inst_valid;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    stage_if dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .br         (br),
        .br_addr    (br_addr),
        .mem_busy   (mem_busy),
        .ram_rd     (ram_rd),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .pc         (pc),
        .inst       (inst),
        .inst_valid (inst_valid)
    );

    // Bytes 0..3 hold addi a0,zero,1; elsewhere a fixed address-derived pattern.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'd0:   return 8'h13;
            32'd1:   return 8'h05;
            32'd2:   return 8'h10;
            32'd3:   return 8'h00;
            default: return a[7:0] ^ a[31:24] ^ 8'hC3;
        endcase
    endfunction

    always @(posedge clk) begin
        if (ram_rd) ram_data <= mem_byte(ram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    // Leaves the bench at the start of cycle 0 (first cycle with reset low).
    task automatic do_reset;
        reset = 1'b1; stall = 1'b0; br = 1'b0; mem_busy = 1'b0;
        nxt();
        smp();
        chk("rst_ram_rd", 32'(ram_rd), 32'd0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        nxt();
        nxt();
        reset = 1'b0;
    endtask

    initial begin
        // 1: plain fetch of the first instruction
        do_reset();
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t1_rd", 32'(ram_rd), 32'd1);
            chk("t1_addr", ram_addr, 32'(k));
            nxt();
        end
        smp();
        chk("t1_c4_rd", 32'(ram_rd), 32'd0);
        chk("t1_c4_valid", 32'(inst_valid), 32'd0);
        nxt();
        smp();
        chk("t1_c5_valid", 32'(inst_valid), 32'd1);
        chk("t1_c5_inst", inst, 32'h00100513);
        chk("t1_c5_pc", pc, 32'h0);
        chk("t1_c5_rd", 32'(ram_rd), 32'd0);
        nxt();
        smp();
        chk("t1_c6_rd", 32'(ram_rd), 32'd1);
        chk("t1_c6_addr", ram_addr, 32'h4);
        chk("t1_c6_valid", 32'(inst_valid), 32'd0);

        // 3: stall while holding the second instruction (fetched c6..c10, valid c11)
        repeat (5) nxt();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            smp();
            chk("t3_valid", 32'(inst_valid), 32'd1);
            chk("t3_pc", pc, 32'h4);
            chk("t3_inst", inst, 32'hC4C5C6C7);
            chk("t3_rd", 32'(ram_rd), 32'd0);
            nxt();
        end
        stall = 1'b0;
        smp();
        chk("t3_release_valid", 32'(inst_valid), 32'd1);
        nxt();
        smp();
        chk("t3_next_rd", 32'(ram_rd), 32'd1);
        chk("t3_next_addr", ram_addr, 32'h8);

        // 2: memory stage owns the port in cycles 1-2
        do_reset();
        smp();
        chk("t2_c0_addr", ram_addr, 32'h0);
        nxt();
        mem_busy = 1'b1;
        smp();
        chk("t2_c1_rd", 32'(ram_rd), 32'd0);
        nxt();
        smp();
        chk("t2_c2_rd", 32'(ram_rd), 32'd0);
        nxt();
        mem_busy = 1'b0;
        for (int k = 1; k < 4; k++) begin
            smp();
            chk("t2_rd", 32'(ram_rd), 32'd1);
            chk("t2_addr", ram_addr, 32'(k));
            nxt();
        end
        smp();
        chk("t2_c6_valid", 32'(inst_valid), 32'd0);
        nxt();
        smp();
        chk("t2_c7_valid", 32'(inst_valid), 32'd1);
        chk("t2_c7_inst", inst, 32'h00100513);

        // 7: redirect together with stall while holding
        stall = 1'b1; br = 1'b1; br_addr = 32'h40;
        smp();
        chk("t7_rd", 32'(ram_rd), 32'd0);
        nxt();
        stall = 1'b0; br = 1'b0;
        smp();
        chk("t7_valid", 32'(inst_valid), 32'd0);
        chk("t7_rd_after", 32'(ram_rd), 32'd1);
        chk("t7_addr_after", ram_addr, 32'h40);

        // 4: redirect in cycle 2 of a fetch
        do_reset();
        smp();
        chk("t4_c0_addr", ram_addr, 32'h0);
        nxt();
        smp();
        chk("t4_c1_addr", ram_addr, 32'h1);
        nxt();
        br = 1'b1; br_addr = 32'h100;
        smp();
        chk("t4_c2_rd", 32'(ram_rd), 32'd0);
        nxt();
        br = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t4_rd", 32'(ram_rd), 32'd1);
            chk("t4_addr", ram_addr, 32'h100 + 32'(k));
            chk("t4_valid_low", 32'(inst_valid), 32'd0);
            nxt();
        end
        smp();
        chk("t4_c7_valid", 32'(inst_valid), 32'd0);
        nxt();
        smp();
        chk("t4_c8_valid", 32'(inst_valid), 32'd1);
        chk("t4_c8_pc", pc, 32'h100);
        chk("t4_c8_inst", inst, 32'hC0C1C2C3);

        // 5: fetch at the top of the address space, then wrap to 0
        do_reset();
        br = 1'b1; br_addr = 32'hFFFF_FFFC; mem_busy = 1'b1;
        smp();
        chk("t5_brbusy_rd", 32'(ram_rd), 32'd0);
        nxt();
        br = 1'b0; mem_busy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            smp();
            chk("t5_addr", ram_addr, 32'hFFFF_FFFC + 32'(k));
            nxt();
        end
        smp();
        chk("t5_c5_valid", 32'(inst_valid), 32'd0);
        nxt();
        smp();
        chk("t5_c6_valid", 32'(inst_valid), 32'd1);
        chk("t5_c6_pc", pc, 32'hFFFF_FFFC);
        chk("t5_c6_inst", inst, 32'hC3C2C1C0);
        nxt();
        smp();
        chk("t5_wrap_rd", 32'(ram_rd), 32'd1);
        chk("t5_wrap_addr", ram_addr, 32'h0);

`ifdef ICACHE_EN
        // 6: second visit to 0x0 hits, reset then misses again
        do_reset();
        repeat (5) nxt();
        br = 1'b1; br_addr = 32'h0;
        smp();
        chk("t6_first_valid", 32'(inst_valid), 32'd1);
        nxt();
        br = 1'b0; mem_busy = 1'b1;
        smp();
        chk("t6_hit_rd", 32'(ram_rd), 32'd0);
        chk("t6_hit_valid_low", 32'(inst_valid), 32'd0);
        nxt();
        mem_busy = 1'b0;
        smp();
        chk("t6_hit_valid", 32'(inst_valid), 32'd1);
        chk("t6_hit_inst", inst, 32'h00100513);
        chk("t6_hit_pc", pc, 32'h0);
        chk("t6_hit_rd2", 32'(ram_rd), 32'd0);
        do_reset();
        smp();
        chk("t6_remiss_rd", 32'(ram_rd), 32'd1);
        chk("t6_remiss_addr", ram_addr, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
